// File: rtl/rtc_bus_responder.sv
// Bus-side model of the RTC chip on the multiplexed a_d/cs/rd/wr/AD bus.
// It holds a 256x8 register file, and the BCD time registers 0x21..0x23 count on their own.
module rtc_bus_responder #(
    parameter int RD_LAT   = 3,
    parameter int TICK_DIV = 100,
    parameter int SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       bus_err
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);
    localparam logic [7:0]        SEC_A     = 8'h21;
    localparam logic [7:0]        MIN_A     = 8'h22;
    localparam logic [7:0]        HRS_A     = 8'h23;

    typedef enum logic [1:0] {
        IDLE,
        WR_LOW,
        RD_WAIT,
        RD_DRV
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_STG-1:0] a_d_sync_q, a_d_sync_d;
    logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STG-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STG-1:0] wr_sync_q, wr_sync_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          ad_out_q, ad_out_d;
    logic                ad_oe_q, ad_oe_d;
    logic                bus_err_q, bus_err_d;
    logic                blocked_q, blocked_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]          regs_q [256];
    logic [7:0]          regs_d [256];

    logic       a_d_s, cs_s, rd_s, wr_s;
    logic       collision, tick;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data;
    logic       adv_min, adv_hrs;

    // Any non-BCD digit or a value at/over the limit rolls to 00 and carries.
    function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v >= max_v);
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v);
        if (bcd_wraps(v, max_v)) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    assign a_d_s     = a_d_sync_q[SYNC_STG-1];
    assign cs_s      = cs_sync_q[SYNC_STG-1];
    assign rd_s      = rd_sync_q[SYNC_STG-1];
    assign wr_s      = wr_sync_q[SYNC_STG-1];
    assign collision = !cs_s && !rd_s && !wr_s;

    // Bus protocol FSM
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d    = state_q;
        a_d_sync_d = {a_d_sync_q[SYNC_STG-2:0], a_d};
        cs_sync_d  = {cs_sync_q[SYNC_STG-2:0], cs};
        rd_sync_d  = {rd_sync_q[SYNC_STG-2:0], rd};
        wr_sync_d  = {wr_sync_q[SYNC_STG-2:0], wr};
        addr_d     = addr_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = ad_oe_q;
        bus_err_d  = 1'b0;
        blocked_d  = blocked_q;
        lat_cnt_d  = lat_cnt_q;
        wr_en      = 1'b0;
        wr_addr    = addr_q;
        wr_data    = ad_in;

        if (collision && !blocked_q) begin
            bus_err_d = 1'b1;
            blocked_d = 1'b1;
            ad_oe_d   = 1'b0;
            state_d   = IDLE;
        end else if (blocked_q) begin
            // One error pulse per violation; the bus re-arms once both strobes are high.
            if (rd_s && wr_s) blocked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_s && !wr_s) begin
                        state_d = WR_LOW;
                    end else if (!cs_s && !rd_s) begin
                        if (a_d_s) begin
                            state_d   = RD_WAIT;
                            lat_cnt_d = 3'd0;
                        end else begin
                            bus_err_d = 1'b1;
                            blocked_d = 1'b1;
                        end
                    end
                end
                WR_LOW: begin
                    if (wr_s || cs_s) begin
                        state_d = IDLE;
                        if (a_d_s) wr_en = 1'b1;
                        else       addr_d = ad_in;
                    end
                end
                RD_WAIT: begin
                    if (rd_s || cs_s) begin
                        state_d = IDLE;
                        ad_oe_d = 1'b0;
                    end else if (lat_cnt_q == LAT_LAST) begin
                        state_d  = RD_DRV;
                        ad_out_d = regs_q[addr_q];
                        ad_oe_d  = 1'b1;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end
                RD_DRV: begin
                    if (rd_s || cs_s) begin
                        state_d = IDLE;
                        ad_oe_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Time-keeping: a bus write to a time register replaces its tick and swallows its carry.
    assign tick    = (tick_cnt_q == TICK_LAST);
    assign adv_min = tick && bcd_wraps(regs_q[SEC_A], 8'h59) && !(wr_en && wr_addr == SEC_A);
    assign adv_hrs = adv_min && bcd_wraps(regs_q[MIN_A], 8'h59) && !(wr_en && wr_addr == MIN_A);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        regs_d     = regs_q;
        if (tick)    regs_d[SEC_A] = bcd_next(regs_q[SEC_A], 8'h59);
        if (adv_min) regs_d[MIN_A] = bcd_next(regs_q[MIN_A], 8'h59);
        if (adv_hrs) regs_d[HRS_A] = bcd_next(regs_q[HRS_A], 8'h23);
        if (wr_en)   regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_d_sync_q <= '0;
            cs_sync_q  <= '1;
            rd_sync_q  <= '1;
            wr_sync_q  <= '1;
            addr_q     <= 8'h00;
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            blocked_q  <= 1'b0;
            lat_cnt_q  <= 3'd0;
            tick_cnt_q <= '0;
            // NOTE: the register file must read 0x00 after reset, so it is built from resettable flops rather than a RAM.
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            a_d_sync_q <= a_d_sync_d;
            cs_sync_q  <= cs_sync_d;
            rd_sync_q  <= rd_sync_d;
            wr_sync_q  <= wr_sync_d;
            addr_q     <= addr_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            bus_err_q  <= bus_err_d;
            blocked_q  <= blocked_d;
            lat_cnt_q  <= lat_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            regs_q     <= regs_d;
        end
    end

    assign ad_out  = ad_out_q;
    assign ad_oe   = ad_oe_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed protocol scenarios plus random reads and writes.
// Expectations come from a decimal time-of-day register model.
module tb_rtc_bus_responder;

    localparam int RD_LAT   = 3;
    localparam int TICK_DIV = 100;
    localparam int SYNC_STG = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a_d   = 1'b0;
    logic       cs    = 1'b1;
    logic       rd    = 1'b1;
    logic       wr    = 1'b1;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       bus_err;

    int errors = 0;
    int checks = 0;

    // Reference state. mdl and cyc are owned by the model process.
    // pend_* and m_addr are owned by the stimulus process.
    logic [7:0] mdl [256];
    int         cyc       = 0;
    int         pend_edge = -1;
    logic [7:0] pend_addr = 8'h00;
    logic [7:0] pend_data = 8'h00;
    logic [7:0] m_addr    = 8'h00;

    always #5 clk = ~clk;

    rtc_bus_responder #(
        .RD_LAT  (RD_LAT),
        .TICK_DIV(TICK_DIV),
        .SYNC_STG(SYNC_STG)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_d    (a_d),
        .cs     (cs),
        .rd     (rd),
        .wr     (wr),
        .ad_in  (ad_in),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .bus_err(bus_err)
    );

    // Advance one BCD time field: the value is read as a decimal number.
    function automatic void tm_step(input logic [7:0] v, input int lim,
                                    output logic [7:0] nv, output bit carry);
        int hi, lo, n;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9 || hi * 10 + lo >= lim) begin
            nv    = 8'h00;
            carry = 1'b1;
        end else begin
            n     = hi * 10 + lo + 1;
            nv    = 8'((n / 10) * 16 + n % 10);
            carry = 1'b0;
        end
    endfunction

    initial forever begin
        int         wa;
        bit         c;
        logic [7:0] nv;
        @(posedge clk);
        if (reset) begin
            cyc = 0;
            for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        end else begin
            cyc = cyc + 1;
            wa  = (cyc == pend_edge) ? int'(pend_addr) : -1;
            if (cyc % TICK_DIV == 0) begin
                c = 1'b1;
                for (int r = 8'h21; r <= 8'h23; r++) begin
                    if (c) begin
                        tm_step(mdl[r], (r == 8'h23) ? 23 : 59, nv, c);
                        if (wa == r) c = 1'b0;
                        else         mdl[r] = nv;
                    end
                end
            end
            if (wa >= 0) mdl[wa] = pend_data;
        end
    end

    // One bus write phase. With align_tick set, wr is held low until the write lands on a tick edge.
    task automatic bus_write(input bit data_ph, input logic [7:0] val, input bit align_tick);
        int hold;
        @(negedge clk);
        cs = 1'b0; a_d = data_ph; ad_in = val;
        @(negedge clk);
        wr   = 1'b0;
        hold = 0;
        do begin
            @(negedge clk);
            hold++;
        end while (hold < SYNC_STG + 2 || (align_tick && ((cyc + SYNC_STG + 1) % TICK_DIV) != 0));
        wr = 1'b1;
        if (data_ph) begin
            pend_addr = m_addr;
            pend_data = val;
            pend_edge = cyc + SYNC_STG + 1;
        end else begin
            m_addr = val;
        end
        repeat (SYNC_STG + 2) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC_STG + 1) @(negedge clk);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
        bus_write(1'b0, a, 1'b0);
        bus_write(1'b1, v, 1'b0);
    endtask

    // A read with rd held low for 10 cycles. It samples ad_oe just before and at the
    // expected drive edge, and again around the release of rd.
    task automatic bus_read(input bit do_addr, input logic [7:0] a,
                            output logic [7:0] got, output logic [7:0] exp,
                            output logic oe_pre, output logic oe_at,
                            output logic oe_hold, output logic oe_off);
        int drv, rel;
        got = 'x; exp = 'x; oe_pre = 'x; oe_at = 'x; oe_hold = 'x; oe_off = 'x;
        if (do_addr) bus_write(1'b0, a, 1'b0);
        @(negedge clk);
        cs = 1'b0; a_d = 1'b1;
        @(negedge clk);
        rd  = 1'b0;
        drv = cyc + SYNC_STG + RD_LAT + 1;
        repeat (10) begin
            @(negedge clk);
            if (cyc == drv - 1) begin
                oe_pre = ad_oe;
                exp    = mdl[m_addr];
            end
            if (cyc == drv) begin
                oe_at = ad_oe;
                got   = ad_out;
            end
        end
        rd  = 1'b1;
        rel = cyc;
        repeat (SYNC_STG + 1) begin
            @(negedge clk);
            if (cyc == rel + SYNC_STG)     oe_hold = ad_oe;
            if (cyc == rel + SYNC_STG + 1) oe_off  = ad_oe;
        end
        cs = 1'b1;
        repeat (SYNC_STG + 1) @(negedge clk);
    endtask

    // Park at the first cycle of a tick window so that directed sequences avoid a tick.
    task automatic align_window(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc % TICK_DIV != 1 && n < 3 * TICK_DIV);
        checks++;
        if (cyc % TICK_DIV != 1) begin
            errors++;
            $display("FAIL %s_align: cycle %0d never reached window start", tag, cyc);
        end
    endtask

    task automatic test_reset();
        logic [7:0] g, e;
        logic p, o, h, f;
        repeat (3) @(negedge clk);
        checks += 3;
        if (ad_oe !== 1'b0)    begin errors++; $display("FAIL rst_oe: got %b want 0", ad_oe); end
        if (ad_out !== 8'h00)  begin errors++; $display("FAIL rst_out: got %h want 00", ad_out); end
        if (bus_err !== 1'b0)  begin errors++; $display("FAIL rst_err: got %b want 0", bus_err); end
        reset = 1'b0;
        bus_read(1'b1, 8'h40, g, e, p, o, h, f);
        checks += 2;
        if (o !== 1'b1)  begin errors++; $display("FAIL rst_rd40_oe: got %b want 1", o); end
        if (g !== 8'h00) begin errors++; $display("FAIL rst_rd40: got %h want 00", g); end
        bus_read(1'b1, 8'hF0, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h00) begin errors++; $display("FAIL rst_rdF0: got %h want 00", g); end
    endtask

    task automatic test_addr_write();
        logic [7:0] g, e;
        logic p, o, h, f;
        bit   oe_seen = 1'b0;
        fork
            reg_write(8'h22, 8'h45);
            repeat (30) begin
                @(negedge clk);
                if (ad_oe !== 1'b0) oe_seen = 1'b1;
            end
        join
        checks++;
        if (oe_seen) begin errors++; $display("FAIL t1_oe: ad_oe rose during a write, want 0"); end
        bus_read(1'b0, 8'h00, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h45) begin errors++; $display("FAIL t1_reg22: got %h want 45", g); end
    endtask

    task automatic test_read_latency();
        logic [7:0] g, e;
        logic p, o, h, f;
        bus_read(1'b1, 8'h22, g, e, p, o, h, f);
        checks += 5;
        if (p !== 1'b0)  begin errors++; $display("FAIL t2_oe_early: got %b want 0", p); end
        if (o !== 1'b1)  begin errors++; $display("FAIL t2_oe_at: got %b want 1", o); end
        if (g !== 8'h45) begin errors++; $display("FAIL t2_data: got %h want 45", g); end
        if (h !== 1'b1)  begin errors++; $display("FAIL t2_oe_hold: got %b want 1", h); end
        if (f !== 1'b0)  begin errors++; $display("FAIL t2_oe_off: got %b want 0", f); end
    endtask

    task automatic test_rollover();
        logic [7:0] g, e;
        logic p, o, h, f;
        align_window("t3");
        reg_write(8'h21, 8'h59);
        reg_write(8'h22, 8'h59);
        reg_write(8'h23, 8'h23);
        align_window("t3b");
        for (int r = 8'h21; r <= 8'h23; r++) begin
            bus_read(1'b1, 8'(r), g, e, p, o, h, f);
            checks++;
            if (g !== 8'h00) begin errors++; $display("FAIL t3_reg%h: got %h want 00", 8'(r), g); end
        end
    endtask

    task automatic test_collision();
        logic [7:0] g, e;
        logic p, o, h, f;
        align_window("t4");
        reg_write(8'h22, 8'h07);
        reg_write(8'h21, 8'h59);
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h10, 1'b1);
        bus_read(1'b1, 8'h21, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h10) begin errors++; $display("FAIL t4_sec: got %h want 10", g); end
        bus_read(1'b1, 8'h22, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h07) begin errors++; $display("FAIL t4_min: got %h want 07", g); end
    endtask

    task automatic test_error();
        logic [7:0] g, e;
        logic p, o, h, f;
        int   pulses = 0;
        bit   oe_seen = 1'b0;
        reg_write(8'h30, 8'h3C);
        @(negedge clk);
        cs = 1'b0; a_d = 1'b1; ad_in = 8'hEE;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_err === 1'b1) pulses++;
            if (ad_oe !== 1'b0) oe_seen = 1'b1;
        end
        rd = 1'b1; wr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus_err === 1'b1) pulses++;
            if (ad_oe !== 1'b0) oe_seen = 1'b1;
        end
        cs = 1'b1;
        repeat (SYNC_STG + 1) @(negedge clk);
        checks += 2;
        if (pulses != 1) begin errors++; $display("FAIL t5_pulse: got %0d cycles want 1", pulses); end
        if (oe_seen)     begin errors++; $display("FAIL t5_oe: ad_oe rose, want 0"); end
        bus_read(1'b0, 8'h00, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h3C) begin errors++; $display("FAIL t5_reg30: got %h want 3c", g); end
    endtask

    task automatic test_addr_read_err();
        logic [7:0] g, e;
        logic p, o, h, f;
        int   pulses = 0;
        bit   oe_seen = 1'b0;
        @(negedge clk);
        cs = 1'b0; a_d = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_err === 1'b1) pulses++;
            if (ad_oe !== 1'b0) oe_seen = 1'b1;
        end
        rd = 1'b1;
        repeat (SYNC_STG + 2) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC_STG + 1) @(negedge clk);
        checks += 2;
        if (pulses != 1) begin errors++; $display("FAIL addr_rd_pulse: got %0d want 1", pulses); end
        if (oe_seen)     begin errors++; $display("FAIL addr_rd_oe: ad_oe rose, want 0"); end
        bus_read(1'b0, 8'h00, g, e, p, o, h, f);
        checks += 2;
        if (o !== 1'b1)  begin errors++; $display("FAIL rearm_oe: got %b want 1", o); end
        if (g !== 8'h3C) begin errors++; $display("FAIL rearm_data: got %h want 3c", g); end
    endtask

    task automatic test_random();
        logic [7:0] g, e, a, v;
        logic p, o, h, f;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h20, 8'h24)) : 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                reg_write(a, v);
            end else begin
                bus_read($urandom_range(0, 2) != 0, a, g, e, p, o, h, f);
                checks += 2;
                if (o !== 1'b1) begin errors++; $display("FAIL rnd_oe[%0d]: got %b want 1", n, o); end
                if (g !== e)    begin errors++; $display("FAIL rnd_data[%0d] addr %h: got %h want %h", n, m_addr, g, e); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] g, e;
        logic p, o, h, f;
        int   n = 0;
        reg_write(8'h22, 8'h45);
        @(negedge clk);
        cs = 1'b0; a_d = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        while (ad_oe !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ad_oe !== 1'b1) begin errors++; $display("FAIL t6_drive: got ad_oe=%b want 1 within 20 cycles", ad_oe); end
        #2 reset = 1'b1;
        #1;
        checks += 2;
        if (ad_oe !== 1'b0)   begin errors++; $display("FAIL t6_oe_async: got %b want 0", ad_oe); end
        if (ad_out !== 8'h00) begin errors++; $display("FAIL t6_out_async: got %h want 00", ad_out); end
        @(negedge clk);
        rd = 1'b1; cs = 1'b1;
        m_addr    = 8'h00;
        pend_edge = -1;
        @(negedge clk);
        reset = 1'b0;
        bus_write(1'b1, 8'h5A, 1'b0);
        bus_read(1'b1, 8'h00, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h5A) begin errors++; $display("FAIL t6_addr0: got %h want 5a", g); end
        bus_read(1'b1, 8'h22, g, e, p, o, h, f);
        checks++;
        if (g !== 8'h00) begin errors++; $display("FAIL t6_reg22: got %h want 00", g); end
    endtask

    initial begin
        test_reset();
        test_addr_write();
        test_read_latency();
        test_rollover();
        test_collision();
        test_error();
        test_addr_read_err();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
